mdio_responder: RTL

MDIO_RESPONDER -- requirements
Module: mdio_responder

---
 rtl/mdio_responder.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/mdio_responder.sv
// MDIO (clause 22) management responder: answers frames addressed to PHY_ADDR on a small register file.
// Optional macro MDIO_PREAMBLE_SUPPRESS_EN: after a completed or aborted frame, accept a shortened preamble.
module mdio_responder #(
   parameter logic [4:0]  PHY_ADDR = 5'h01,
   parameter logic [15:0] PHY_ID1  = 16'h0022,
   parameter logic [15:0] PHY_ID2  = 16'h1560
) (
   input  logic        clk_rmii,
   input  logic        rst,
   input  logic        i_mdc,
   input  logic        i_mdio,
   output logic        o_mdio,
   output logic        oe_mdio,
   input  logic [15:0] status_i,
   output logic [15:0] ctrl_o,
   output logic        frame_done
);

   typedef enum logic [2:0] {IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA} state_t;

   state_t      state, state_nxt;
   logic        mdc_p0, mdc_p1, mdc_p2;
   logic        mdio_p0, mdio_p1;
   logic        mdc_rise, bit_in;
   logic [4:0]  bit_cnt, bit_cnt_nxt;
   logic [5:0]  pre_cnt, pre_cnt_nxt;
   logic        pre_ok;
   logic        op_msb, op_msb_nxt;
   logic        op_rd, op_rd_nxt;
   logic [14:0] sh_in, sh_in_nxt;
   logic        adr_ok, adr_ok_nxt;
   logic [4:0]  reg_ad, reg_ad_nxt;
   logic [15:0] rd_sr, rd_sr_nxt;
   logic        oe_q, oe_nxt;
   logic        od_q, od_nxt;
   logic        done_nxt;
   logic        wr_en;
   logic [15:0] wr_data;
   logic        soft_pend;
   logic [4:0]  ra_now;
   logic [15:0] rd_mux;
   logic [15:0] reg0;
   logic [15:0] scratch [4];

   function automatic logic [5:0] sat_inc(input logic [5:0] c);
      return (c == 6'd32) ? c : c + 6'd1;
   endfunction

   assign mdc_rise   = mdc_p1 & ~mdc_p2;
   assign bit_in     = mdio_p1;
   assign ra_now     = {sh_in[3:0], bit_in};
   assign wr_data    = {sh_in, bit_in};
   assign o_mdio     = od_q;
   assign oe_mdio    = oe_q;
   assign ctrl_o     = reg0;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
   logic seen_frame;

   always_ff @(posedge clk_rmii) begin
      if (rst)
         seen_frame <= 1'b0;
      else if (state != IDLE && state_nxt == IDLE)
         seen_frame <= 1'b1;
   end

   assign pre_ok = (pre_cnt == 6'd32) || (seen_frame && pre_cnt != 6'd0);
`else
   assign pre_ok = (pre_cnt == 6'd32);
`endif

   // Read value is captured on the edge carrying the last register-address bit.
   always_comb begin
      rd_mux = 16'h0000;
      case (ra_now)
         5'd0:                      rd_mux = reg0;
         5'd1:                      rd_mux = status_i;
         5'd2:                      rd_mux = PHY_ID1;
         5'd3:                      rd_mux = PHY_ID2;
         5'd4, 5'd5, 5'd6, 5'd7:    rd_mux = scratch[ra_now[1:0]];
         default:                   rd_mux = 16'h0000;
      endcase
   end

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      pre_cnt_nxt = pre_cnt;
      op_msb_nxt  = op_msb;
      op_rd_nxt   = op_rd;
      sh_in_nxt   = sh_in;
      adr_ok_nxt  = adr_ok;
      reg_ad_nxt  = reg_ad;
      rd_sr_nxt   = rd_sr;
      oe_nxt      = oe_q;
      od_nxt      = od_q;
      done_nxt    = 1'b0;
      wr_en       = 1'b0;
      if (mdc_rise) begin
         bit_cnt_nxt = bit_cnt + 5'd1;
         sh_in_nxt   = {sh_in[13:0], bit_in};
         case (state)
            IDLE: begin
               bit_cnt_nxt = 5'd0;
               if (bit_in) begin
                  pre_cnt_nxt = sat_inc(pre_cnt);
               end else begin
                  pre_cnt_nxt = 6'd0;
                  if (pre_ok)
                     state_nxt = ST;
               end
            end
            ST: begin
               bit_cnt_nxt = 5'd0;
               state_nxt   = bit_in ? OP : IDLE;
            end
            OP: begin
               if (bit_cnt == 5'd0) begin
                  op_msb_nxt = bit_in;
               end else begin
                  bit_cnt_nxt = 5'd0;
                  op_rd_nxt   = op_msb;
                  state_nxt   = (op_msb != bit_in) ? PHYAD : IDLE;
               end
            end
            PHYAD: begin
               if (bit_cnt == 5'd4) begin
                  bit_cnt_nxt = 5'd0;
                  adr_ok_nxt  = (ra_now == PHY_ADDR);
                  state_nxt   = REGAD;
               end
            end
            REGAD: begin
               if (bit_cnt == 5'd4) begin
                  bit_cnt_nxt = 5'd0;
                  reg_ad_nxt  = ra_now;
                  rd_sr_nxt   = rd_mux;
                  state_nxt   = TA;
               end
            end
            TA: begin
               if (bit_cnt == 5'd0) begin
                  oe_nxt = op_rd & adr_ok;
                  od_nxt = 1'b0;
               end else begin
                  bit_cnt_nxt = 5'd0;
                  if (op_rd) begin
                     od_nxt    = oe_q & rd_sr[15];
                     rd_sr_nxt = {rd_sr[14:0], 1'b0};
                     state_nxt = RDATA;
                  end else begin
                     state_nxt = WDATA;
                  end
               end
            end
            RDATA: begin
               if (bit_cnt == 5'd15) begin
                  oe_nxt    = 1'b0;
                  od_nxt    = 1'b0;
                  done_nxt  = adr_ok;
                  state_nxt = IDLE;
               end else begin
                  od_nxt    = oe_q & rd_sr[15];
                  rd_sr_nxt = {rd_sr[14:0], 1'b0};
               end
            end
            WDATA: begin
               if (bit_cnt == 5'd15) begin
                  wr_en     = adr_ok;
                  done_nxt  = adr_ok;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_rmii) begin
      if (rst) begin
         mdc_p0     <= 1'b1;
         mdc_p1     <= 1'b1;
         mdc_p2     <= 1'b1;
         mdio_p0    <= 1'b1;
         mdio_p1    <= 1'b1;
         state      <= IDLE;
         bit_cnt    <= 5'd0;
         pre_cnt    <= 6'd0;
         op_msb     <= 1'b0;
         op_rd      <= 1'b0;
         sh_in      <= '0;
         adr_ok     <= 1'b0;
         reg_ad     <= 5'd0;
         rd_sr      <= '0;
         oe_q       <= 1'b0;
         od_q       <= 1'b0;
         frame_done <= 1'b0;
         soft_pend  <= 1'b0;
         reg0       <= 16'h0000;
         for (int i = 0; i < 4; i++) scratch[i] <= 16'h0000;
      end else begin
         mdc_p0     <= i_mdc;
         mdc_p1     <= mdc_p0;
         mdc_p2     <= mdc_p1;
         mdio_p0    <= i_mdio;
         mdio_p1    <= mdio_p0;
         state      <= state_nxt;
         bit_cnt    <= bit_cnt_nxt;
         pre_cnt    <= pre_cnt_nxt;
         op_msb     <= op_msb_nxt;
         op_rd      <= op_rd_nxt;
         sh_in      <= sh_in_nxt;
         adr_ok     <= adr_ok_nxt;
         reg_ad     <= reg_ad_nxt;
         rd_sr      <= rd_sr_nxt;
         oe_q       <= oe_nxt;
         od_q       <= od_nxt;
         frame_done <= done_nxt;
         // Soft reset lands one cycle after the register-0 write that requested it.
         soft_pend  <= wr_en && (reg_ad == 5'd0) && wr_data[15];
         if (soft_pend) begin
            reg0 <= 16'h0000;
            for (int i = 0; i < 4; i++) scratch[i] <= 16'h0000;
         end else if (wr_en) begin
            case (reg_ad)
               5'd0:                   reg0 <= {1'b0, wr_data[14:0]};
               5'd4, 5'd5, 5'd6, 5'd7: scratch[reg_ad[1:0]] <= wr_data;
               default: ;
            endcase
         end
      end
   end

endmodule
